// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mem_pkg
// Purpose  : Shared state, size and error encodings for mem_access_unit.
// Revision : 1.0
// ============================================================================
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ALIGN   = 2'b01;
    localparam logic [1:0] ERR_SIZE    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    function automatic int size_bytes(input logic [1:0] size);
        return 1 << size;
    endfunction

    function automatic logic [1:0] size_code(input int nbytes);
        return 2'($clog2(nbytes));
    endfunction

endpackage
`default_nettype wire

// File: rtl/lane_steer.sv
`default_nettype none
// ============================================================================
// Module   : lane_steer
// Purpose  : Byte-lane enables, store-data steering and load extraction with
//            sign/zero extension for one access of 1<<size bytes at a lane.
// Revision : 1.0
// ============================================================================
module lane_steer
    import mem_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int LANE_W = 3
) (
    input  logic [1:0]          size,
    input  logic [LANE_W-1:0]   lane,
    input  logic                sign_ext,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W-1:0]   rdata_raw,
    output logic [DATA_W/8-1:0] be,
    output logic [DATA_W-1:0]   wdata_sh,
    output logic [DATA_W-1:0]   rdata_ext
);

    localparam int L = DATA_W / 8;

    int                w_nbytes;
    logic [L-1:0]      w_mask;
    logic [DATA_W-1:0] w_shifted;
    logic              w_msb;

    always_comb begin
        w_nbytes  = size_bytes(size);
        w_shifted = rdata_raw >> (8 * lane);
        w_mask    = '0;
        w_msb     = 1'b0;
        for (int i = 0; i < L; i++) begin
            if (i < w_nbytes) begin
                w_mask[i] = 1'b1;
            end
            if (i == w_nbytes - 1) begin
                w_msb = w_shifted[8*i+7];
            end
        end
        // Lanes beyond the access width are filled with the extension byte.
        rdata_ext = '0;
        for (int i = 0; i < L; i++) begin
            rdata_ext[8*i +: 8] = w_mask[i] ? w_shifted[8*i +: 8] : {8{sign_ext & w_msb}};
        end
        be       = w_mask << lane;
        wdata_sh = wdata << (8 * lane);
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Registered req/ack memory port sequencing instruction fetch and
//            data load/store with alignment checks, lane steering and timeout.
// Revision : 1.0
// ============================================================================
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  fetch_req,
    input  logic [ADDR_W-1:0]     pc_addr,
    input  logic                  data_req,
    input  logic                  data_we,
    input  logic [ADDR_W-1:0]     data_addr,
    input  logic [1:0]            data_size,
    input  logic                  sign_ext,
    input  logic [DATA_W-1:0]     data_wdata,
    output logic [INSTR_W-1:0]    instr,
    output logic                  instr_valid,
    output logic [DATA_W-1:0]     rdata,
    output logic                  data_done,
    output logic                  err,
    output logic [1:0]            err_code,
    output logic                  busy,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int         L      = DATA_W / 8;
    localparam int         LANE_W = (L > 1) ? $clog2(L) : 1;
    localparam logic [1:0] ISIZE  = size_code(INSTR_W / 8);
    localparam int         CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_size;
    logic [LANE_W-1:0]  r_lane;
    logic               r_sext;

    logic [ADDR_W-1:0]  w_acc_addr;
    logic [1:0]         w_acc_size;
    logic [2:0]         w_align_mask;
    logic               w_size_err;
    logic               w_align_err;
    logic [1:0]         w_st_size;
    logic [LANE_W-1:0]  w_st_lane;
    logic [L-1:0]       w_be;
    logic [DATA_W-1:0]  w_wdata_sh;
    logic [DATA_W-1:0]  w_rdata_ext;

    always_comb begin
        w_acc_addr   = data_req ? data_addr : pc_addr;
        w_acc_size   = data_req ? data_size : ISIZE;
        w_size_err   = size_bytes(w_acc_size) > L;
        w_align_mask = 3'(size_bytes(w_acc_size) - 1);
        w_align_err  = (w_acc_addr[2:0] & w_align_mask) != 3'd0;
        // One steering block serves the request side in IDLE and the response side afterwards.
        w_st_size    = (r_state == IDLE) ? w_acc_size : r_size;
        w_st_lane    = (r_state == IDLE) ? w_acc_addr[LANE_W-1:0] : r_lane;
    end

    lane_steer #(
        .DATA_W (DATA_W),
        .LANE_W (LANE_W)
    ) u_lane_steer (
        .size      (w_st_size),
        .lane      (w_st_lane),
        .sign_ext  (r_sext),
        .wdata     (data_wdata),
        .rdata_raw (mem_rdata),
        .be        (w_be),
        .wdata_sh  (w_wdata_sh),
        .rdata_ext (w_rdata_ext)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_size      <= '0;
            r_lane      <= '0;
            r_sext      <= 1'b0;
            instr       <= '0;
            instr_valid <= 1'b0;
            rdata       <= '0;
            data_done   <= 1'b0;
            err         <= 1'b0;
            err_code    <= ERR_NONE;
            busy        <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_be      <= '0;
            mem_wdata   <= '0;
        end else begin
            instr_valid <= 1'b0;
            data_done   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (data_req || fetch_req) begin
                        r_size <= w_acc_size;
                        r_lane <= w_acc_addr[LANE_W-1:0];
                        r_sext <= data_req & sign_ext;
                        r_cnt  <= '0;
                        busy   <= 1'b1;
                        if (w_size_err || w_align_err) begin
                            err         <= 1'b1;
                            err_code    <= w_size_err ? ERR_SIZE : ERR_ALIGN;
                            instr_valid <= ~data_req;
                            data_done   <= data_req;
                            r_state     <= RESP;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= data_req & data_we;
                            mem_addr  <= {w_acc_addr[ADDR_W-1:LANE_W], LANE_W'(0)};
                            mem_be    <= w_be;
                            mem_wdata <= w_wdata_sh;
                            r_state   <= data_req ? DATA : FETCH;
                        end
                    end
                end
                FETCH, DATA: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        // Stores complete without disturbing the last load result.
                        if (r_state == FETCH) begin
                            instr <= w_rdata_ext[INSTR_W-1:0];
                        end else if (!mem_we) begin
                            rdata <= w_rdata_ext;
                        end
                        err         <= 1'b0;
                        err_code    <= ERR_NONE;
                        instr_valid <= (r_state == FETCH);
                        data_done   <= (r_state == DATA);
                        r_state     <= RESP;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        mem_req     <= 1'b0;
                        mem_we      <= 1'b0;
                        err         <= 1'b1;
                        err_code    <= ERR_TIMEOUT;
                        instr_valid <= (r_state == FETCH);
                        data_done   <= (r_state == DATA);
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESP: begin
                    busy     <= 1'b0;
                    err      <= 1'b0;
                    err_code <= ERR_NONE;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Scoreboard bench: directed accesses push expected memory requests
//            and responses; monitors compare as the DUT presents them.
// Revision : 1.0
// ============================================================================
module tb_mem_access_unit;
    import mem_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_req = 1'b0;
    logic [31:0] pc_addr = '0;
    logic        data_req = 1'b0;
    logic        data_we = 1'b0;
    logic [31:0] data_addr = '0;
    logic [1:0]  data_size = '0;
    logic        sign_ext = 1'b0;
    logic [63:0] data_wdata = '0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [63:0] rdata;
    logic        data_done;
    logic        err;
    logic [1:0]  err_code;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_be;
    logic [63:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [63:0] mem_rdata = '0;

    mem_access_unit #(
        .DATA_W  (64),
        .ADDR_W  (32),
        .INSTR_W (32),
        .TIMEOUT (15)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .fetch_req   (fetch_req),
        .pc_addr     (pc_addr),
        .data_req    (data_req),
        .data_we     (data_we),
        .data_addr   (data_addr),
        .data_size   (data_size),
        .sign_ext    (sign_ext),
        .data_wdata  (data_wdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .rdata       (rdata),
        .data_done   (data_done),
        .err         (err),
        .err_code    (err_code),
        .busy        (busy),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_be      (mem_be),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        bit          we;
        logic [7:0]  be;
        logic [63:0] wdata;
    } req_t;

    typedef struct {
        bit          is_data;
        bit          err;
        logic [1:0]  code;
        logic [63:0] val;
        bit          chk_val;
    } rsp_t;

    req_t  exp_req[$];
    rsp_t  exp_rsp[$];
    req_t  cur_req;
    rsp_t  cur_rsp;
    int    checks = 0;
    int    errors = 0;
    string tag = "reset";

    int           ack_delay = 0;
    logic [63:0]  resp_data = '0;
    int           req_cycles = 0;
    int           last_req_len = 0;
    logic [104:0] hold_vec;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s: got %0h expected %0h", tag, name, act, exp);
        end
    endtask

    // Memory model and request monitor; ack_delay < 0 never acknowledges.
    always @(negedge clock) begin
        if (mem_req) begin
            if (req_cycles == 0) begin
                hold_vec = {mem_addr, mem_we, mem_be, mem_wdata};
                if (exp_req.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL %s/unexpected_mem_req: got addr %0h expected no request", tag, mem_addr);
                end else begin
                    cur_req = exp_req.pop_front();
                    check("mem_addr", mem_addr, cur_req.addr);
                    check("mem_we", mem_we, cur_req.we);
                    check("mem_be", mem_be, cur_req.be);
                    if (cur_req.we) check("mem_wdata", mem_wdata, cur_req.wdata);
                end
            end else begin
                check("mem_hold", {mem_addr, mem_we, mem_be, mem_wdata}, hold_vec);
            end
            mem_ack   = (ack_delay >= 0) && (req_cycles == ack_delay);
            mem_rdata = resp_data;
            req_cycles++;
        end else begin
            if (req_cycles != 0) last_req_len = req_cycles;
            req_cycles = 0;
            mem_ack    = 1'b0;
        end
    end

    always @(negedge clock) begin
        if (instr_valid || data_done) begin
            if (exp_rsp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s/unexpected_done: got iv=%0b dd=%0b expected no pulse", tag, instr_valid, data_done);
            end else begin
                cur_rsp = exp_rsp.pop_front();
                check("rsp_kind", {instr_valid, data_done}, cur_rsp.is_data ? 2'b01 : 2'b10);
                check("rsp_err", {err, err_code}, {cur_rsp.err, cur_rsp.code});
                if (cur_rsp.chk_val)
                    check("rsp_val", cur_rsp.is_data ? rdata : {32'h0, instr}, cur_rsp.val);
            end
        end
    end

    task automatic wait_done(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clock);
            if (instr_valid || data_done) begin
                n = i;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL %s/wait_done: got no pulse expected one within %0d cycles", tag, budget);
    endtask

    task automatic run_data(input bit we, input logic [31:0] addr, input logic [1:0] size,
                            input bit sx, input logic [63:0] wd, input int delay,
                            input logic [63:0] rd, input logic [31:0] e_addr,
                            input logic [7:0] e_be, input logic [63:0] e_wd,
                            input logic [1:0] e_code, input logic [63:0] e_val, input int e_lat);
        int n;
        if (e_code == ERR_NONE || e_code == ERR_TIMEOUT)
            exp_req.push_back('{e_addr, we, e_be, e_wd});
        exp_rsp.push_back('{1'b1, e_code != ERR_NONE, e_code, e_val, !we});
        ack_delay  = delay;
        resp_data  = rd;
        data_we    = we;
        data_addr  = addr;
        data_size  = size;
        sign_ext   = sx;
        data_wdata = wd;
        data_req   = 1'b1;
        wait_done(40, n);
        data_req = 1'b0;
        check("latency", n, e_lat);
        @(negedge clock);
        check("busy_after", busy, 1'b0);
    endtask

    task automatic run_fetch(input logic [31:0] pc, input int delay, input logic [63:0] rd,
                             input logic [31:0] e_addr, input logic [7:0] e_be,
                             input logic [1:0] e_code, input logic [31:0] e_val, input int e_lat);
        int n;
        if (e_code == ERR_NONE)
            exp_req.push_back('{e_addr, 1'b0, e_be, 64'h0});
        exp_rsp.push_back('{1'b0, e_code != ERR_NONE, e_code, {32'h0, e_val}, 1'b1});
        ack_delay = delay;
        resp_data = rd;
        pc_addr   = pc;
        fetch_req = 1'b1;
        wait_done(40, n);
        fetch_req = 1'b0;
        check("latency", n, e_lat);
        @(negedge clock);
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clock);
        check("rst_ctrl", {instr_valid, data_done, err, err_code, busy, mem_req, mem_we, mem_be}, 0);
        check("rst_rdata", rdata, 0);
        check("rst_instr", instr, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        reset = 1'b0;
        @(negedge clock);

        tag = "t1_ld_half";
        run_data(0, 32'h1006, SZ_H, 1, 64'h0, 0, 64'h8001_0000_0000_0000,
                 32'h1000, 8'hC0, 64'h0, ERR_NONE, 64'hFFFF_FFFF_FFFF_8001, 2);
        tag = "t2_st_byte";
        run_data(1, 32'h2003, SZ_B, 0, 64'hAB, 3, 64'hDEAD_DEAD_DEAD_DEAD,
                 32'h2000, 8'h08, 64'hAB00_0000, ERR_NONE, 64'h0, 5);
        check("t2_req_len", last_req_len, 4);
        check("t2_rdata_kept", rdata, 64'hFFFF_FFFF_FFFF_8001);
        tag = "ld_byte_zx";
        run_data(0, 32'h1005, SZ_B, 0, 64'h0, 1, 64'h0000_9A00_0000_0000,
                 32'h1000, 8'h20, 64'h0, ERR_NONE, 64'h9A, 3);
        tag = "ld_word_sx";
        run_data(0, 32'h1004, SZ_W, 1, 64'h0, 0, 64'h8765_4321_0000_0000,
                 32'h1000, 8'hF0, 64'h0, ERR_NONE, 64'hFFFF_FFFF_8765_4321, 2);
        tag = "ld_dword";
        run_data(0, 32'h1008, SZ_D, 1, 64'h0, 2, 64'h8123_4567_89AB_CDEF,
                 32'h1008, 8'hFF, 64'h0, ERR_NONE, 64'h8123_4567_89AB_CDEF, 4);
        tag = "st_half";
        run_data(1, 32'h200A, SZ_H, 0, 64'h1234, 0, 64'h0,
                 32'h2008, 8'h0C, 64'h1234_0000, ERR_NONE, 64'h0, 2);

        tag = "t3_priority";
        exp_req.push_back('{32'h10, 1'b0, 8'hFF, 64'h0});
        exp_req.push_back('{32'h0, 1'b0, 8'h0F, 64'h0});
        exp_rsp.push_back('{1'b1, 1'b0, ERR_NONE, 64'h1111_2222_3333_4444, 1'b1});
        exp_rsp.push_back('{1'b0, 1'b0, ERR_NONE, 64'hCCCC_DDDD, 1'b1});
        ack_delay = 0;
        resp_data = 64'h1111_2222_3333_4444;
        pc_addr   = 32'h0;
        fetch_req = 1'b1;
        data_we   = 1'b0;
        data_addr = 32'h10;
        data_size = SZ_D;
        sign_ext  = 1'b0;
        data_req  = 1'b1;
        wait_done(40, n);
        check("t3_data_first", data_done, 1'b1);
        data_req  = 1'b0;
        resp_data = 64'hAAAA_BBBB_CCCC_DDDD;
        ack_delay = 1;
        wait_done(40, n);
        check("t3_fetch_second", instr_valid, 1'b1);
        fetch_req = 1'b0;
        @(negedge clock);

        tag = "t4_misalign";
        run_data(0, 32'h1002, SZ_W, 0, 64'h0, 0, 64'h0,
                 32'h0, 8'h0, 64'h0, ERR_ALIGN, 64'h1111_2222_3333_4444, 1);
        tag = "t4_fetch_hi";
        run_fetch(32'h4, 0, 64'h1357_9BDF_2468_ACE0, 32'h0, 8'hF0, ERR_NONE, 32'h1357_9BDF, 2);
        tag = "fetch_misalign";
        run_fetch(32'h6, 0, 64'h0, 32'h0, 8'h0, ERR_ALIGN, 32'h1357_9BDF, 1);

        tag = "t5_timeout";
        run_data(0, 32'h3000, SZ_D, 0, 64'h0, -1, 64'h0,
                 32'h3000, 8'hFF, 64'h0, ERR_TIMEOUT, 64'h1111_2222_3333_4444, 16);
        check("t5_req_len", last_req_len, 15);

        tag = "idle_ack";
        ack_delay = 0;
        mem_ack = 1'b1;
        #1 mem_ack = 1'b1;
        @(negedge clock);
        check("idle_ack_busy", {busy, mem_req}, 2'b00);

        tag = "t6_reset";
        exp_req.push_back('{32'h4000, 1'b0, 8'hFF, 64'h0});
        ack_delay  = -1;
        data_we    = 1'b0;
        data_addr  = 32'h4000;
        data_size  = SZ_D;
        data_wdata = 64'h0;
        data_req   = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("t6_req_before", {mem_req, busy}, 2'b11);
        #2 reset = 1'b1;
        #1 check("t6_async_clear", {mem_req, busy, data_done}, 3'b000);
        data_req = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        check("t6_quiet", {busy, mem_req, data_done}, 3'b000);
        tag = "t6_fetch";
        run_fetch(32'h8, 0, 64'h0BAD_F00D_CAFE_BEEF, 32'h8, 8'h0F, ERR_NONE, 32'hCAFE_BEEF, 2);

        tag = "end";
        check("queues_empty", exp_req.size() + exp_rsp.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of run expected completion before 100us");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
